// File: rtl/dsp48_pkg.sv
// Shared definitions for the DSP48 operand/result pipeline blocks.
// Width helpers and the fill state encoding used by the register chain.
package dsp48_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FILL   = 2'd1,
        PRIMED = 2'd2
    } fill_state_e;

    function automatic int clog2(input int unsigned v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        return r;
    endfunction

    // Latency select must encode 0..depth inclusive
    function automatic int lat_w(input int unsigned depth);
        return clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One data+valid register of the pipeline chain.
// Clear on rst or flush wins over a ce-qualified load.
module pipe_stage #(
    parameter int unsigned    N      = 18,
    parameter logic [N-1:0]   RSTVAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         ce,
    input  logic [N-1:0] d_in,
    input  logic         v_in,
    output logic [N-1:0] d_out,
    output logic         v_out
);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            d_out <= RSTVAL;
            v_out <= 1'b0;
        end else if (ce) begin
            d_out <= d_in;
            v_out <= v_in;
        end
    end

endmodule

// File: rtl/reg_pipe_chain.sv
// Runtime-selectable pipeline register chain with fill tracking.
// Tap 0 is a combinational bypass; taps 1..DEPTH are registered stages.
module reg_pipe_chain
    import dsp48_pkg::*;
#(
    parameter int unsigned  N           = 18,
    parameter int unsigned  DEPTH       = 4,
    parameter int unsigned  DEFAULT_LAT = 1,
    parameter logic [N-1:0] RSTVAL      = '0,
    localparam int unsigned LAT_W       = lat_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             flush,
    input  logic [LAT_W-1:0] lat_sel,
    input  logic [N-1:0]     in_data,
    input  logic             in_valid,
    output logic [N-1:0]     out_data,
    output logic             out_valid,
    output logic             primed,
    output logic [LAT_W-1:0] lat_q
);

    localparam logic [LAT_W-1:0] DEPTH_L = LAT_W'(DEPTH);
    localparam logic [LAT_W-1:0] DEF_LAT = LAT_W'(DEFAULT_LAT);

    // Index 0 carries the live input so the tap mux covers the bypass case
    logic [DEPTH:0][N-1:0] d_pipe;
    logic [DEPTH:0]        vld_pipe;

    assign d_pipe[0]   = in_data;
    assign vld_pipe[0] = in_valid;

    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
        pipe_stage #(
            .N      (N),
            .RSTVAL (RSTVAL)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .ce    (ce),
            .d_in  (d_pipe[k-1]),
            .v_in  (vld_pipe[k-1]),
            .d_out (d_pipe[k]),
            .v_out (vld_pipe[k])
        );
    end

    logic [LAT_W-1:0] lat_clamp;
    logic             lat_chg;
    logic [LAT_W:0]   fill_inc;
    logic [LAT_W-1:0] fill_nxt;
    logic [LAT_W-1:0] fill_cnt;
    fill_state_e      state;

    assign lat_clamp = (lat_sel > DEPTH_L) ? DEPTH_L : lat_sel;
    assign lat_chg   = (lat_clamp != lat_q);
    // One extra bit so fill_cnt+1 cannot wrap when DEPTH = 2**LAT_W-1
    assign fill_inc  = {1'b0, fill_cnt} + 1'b1;
    assign fill_nxt  = (fill_inc > {1'b0, DEPTH_L}) ? DEPTH_L : fill_inc[LAT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_q    <= DEF_LAT;
            fill_cnt <= '0;
            state    <= EMPTY;
        end else if (flush) begin
            if (lat_chg) lat_q <= lat_clamp;
            fill_cnt <= '0;
            state    <= EMPTY;
        end else if (lat_chg) begin
            lat_q    <= lat_clamp;
            fill_cnt <= '0;
            state    <= EMPTY;
        end else if (ce) begin
            fill_cnt <= fill_nxt;
            state    <= (lat_q == '0 || fill_nxt >= lat_q) ? PRIMED : FILL;
        end
    end

    assign primed    = (lat_q == '0) || (state == PRIMED);
    assign out_data  = d_pipe[lat_q];
    assign out_valid = vld_pipe[lat_q] & primed;

endmodule
